// File: rtl/mul_pp_sequencer_if.sv
// Operand/result handshake bundle between the stimulus source and the
// partial-product load sequencer.
interface mul_pp_sequencer_if #(
  parameter int N = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             res_valid;
  logic             res_ready;
  logic [2*N:0]     res_prod;
  logic             res_mismatch;

  // Stimulus source side: offers operands, consumes verdicts.
  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_prod, res_mismatch
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_prod, res_mismatch
  );
endinterface

// File: rtl/mul_pp_sequencer.sv
// Sequencer that serially loads every partial-product bit of a*b into the
// per-column shift registers feeding the NxN compressor, then captures the
// compressor output once and reports whether it equals the true product.
module mul_pp_sequencer #(
  parameter int N    = 25,
  parameter int LAT  = 0,
  parameter int ERRW = 16
) (
  input  logic                clk,
  input  logic                rst,
  mul_pp_sequencer_if.slave   bus,
  output logic [2*N-2:0]      col_bit,
  input  logic [2*N:0]        cmp_dst,
  output logic                busy,
  output logic [ERRW-1:0]     err_cnt
);

  localparam int NCOL = 2 * N - 1;
  localparam int TMAX = (N > LAT) ? N : LAT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [TW-1:0] T_LOAD_LAST = TW'(N - 1);
  localparam logic [TW-1:0] T_WAIT_LAST = (LAT > 0) ? TW'(LAT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [2*N:0]      prod_q, prod_d;
  logic              mis_q, mis_d;
  logic [ERRW-1:0]   err_q, err_d;
  logic [2*N-1:0]    prod_w;

  // Reference product of the latched operands, compared against the capture.
  assign prod_w = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};

  // State and datapath registers; reset abandons any load in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update: step counter, operand latch, capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    mis_d   = mis_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          state_d = LOAD;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
        end
      end
      LOAD: begin
        if (t_q == T_LOAD_LAST) begin
          t_d     = '0;
          state_d = (LAT > 0) ? WAIT : CAPT;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      WAIT: begin
        if (t_q == T_WAIT_LAST) begin
          t_d     = '0;
          state_d = CAPT;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      CAPT: begin
        prod_d  = cmp_dst;
        mis_d   = (cmp_dst != {1'b0, prod_w});
        if (mis_d && (err_q != {ERRW{1'b1}})) begin
          err_d = err_q + ERRW'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake flags and the per-column serial bits during LOAD.
  always_comb begin
    int h;
    int ilo;
    int p;
    h             = 0;
    ilo           = 0;
    p             = 0;
    bus.in_ready  = (state_q == IDLE);
    bus.res_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
    col_bit       = '0;
    if (state_q == LOAD) begin
      for (int k = 0; k < NCOL; k++) begin
        // Column k holds h partial products a[i]*b[k-i], i = ilo..ilo+h-1.
        // Leading zeros are shifted first so the last h edges load them.
        h   = (k + 1 < NCOL - k) ? (k + 1) : (NCOL - k);
        ilo = (k - N + 1 > 0) ? (k - N + 1) : 0;
        p   = int'(t_q) - (N - h);
        if (p >= 0) begin
          col_bit[k] = a_q[IW'(ilo + p)] & b_q[IW'(k - ilo - p)];
        end
      end
    end
  end

  assign bus.res_prod     = prod_q;
  assign bus.res_mismatch = mis_q;
  assign err_cnt          = err_q;

endmodule
